// File: rtl/addr8s_chk_pkg.sv
// addr8s_chk_pkg: shared widths, FSM states and sign-extension helper for the serial checker
package addr8s_chk_pkg;
  localparam int W_DEF = 8;
  localparam int CNT_W_DEF = 16;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic [W_DEF:0] sext(input logic [W_DEF-1:0] x);
    return {x[W_DEF-1], x};
  endfunction
endpackage

// File: rtl/addr8s_serial_checker_serial_sub_cell.sv
// serial_sub_cell: one-bit full subtractor (o + ~b + c) with its carry flop, carry starts at 1
module serial_sub_cell (
  input  logic clk,
  input  logic rst,
  input  logic init,
  input  logic en,
  input  logic o,
  input  logic b,
  output logic d
);
  logic c;
  logic c_out;
  assign d = o ^ ~b ^ c;
  assign c_out = (o & ~b) | (o & c) | (~b & c);
  // carry is reloaded with the two's-complement +1 on every new transaction
  always_ff @(posedge clk)
    if (rst || init) c <= 1'b1;
    else if (en) c <= c_out;
endmodule

// File: rtl/addr8s_serial_checker.sv
// addr8s_serial_checker: bit-serial recovery of A' = O - B and comparison against sext(A)
module addr8s_serial_checker
  import addr8s_chk_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [W:0]       in_o,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W:0]       out_diff,
  output logic             out_err,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  localparam int IW = $clog2(W + 2);
  state_t state, state_nx;
  logic [IW-1:0] idx;
  logic [W:0] a_sx, b_sh, o_sh, d_nx;
  logic d_bit, accept, run, last;
  serial_sub_cell u_cell (
    .clk  (clk),
    .rst  (rst),
    .init (accept),
    .en   (run),
    .o    (o_sh[0]),
    .b    (b_sh[0]),
    .d    (d_bit)
  );
  // handshake decode and next state, all derived from registered state
  always_comb begin
    accept = in_valid && state == IDLE;
    run = state == RUN;
    last = run && idx == IW'(W);
    d_nx = {d_bit, out_diff[W:1]};
    in_ready = state == IDLE;
    out_valid = state == DONE;
    state_nx = state == IDLE ? (in_valid ? RUN : IDLE) :
               state == RUN  ? (last ? DONE : RUN) :
                               (out_ready ? IDLE : DONE);
  end
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // operand shifters; difference shifts in MSB-side so it lands LSB-aligned after W+1 bits
  always_ff @(posedge clk)
    if (rst) begin
      idx <= '0;
      a_sx <= '0;
      b_sh <= '0;
      o_sh <= '0;
      out_diff <= '0;
      out_err <= 1'b0;
    end else if (accept) begin
      idx <= '0;
      a_sx <= {in_a[W-1], in_a};
      b_sh <= {in_b[W-1], in_b};
      o_sh <= in_o;
    end else if (run) begin
      idx <= idx + IW'(1);
      b_sh <= b_sh >> 1;
      o_sh <= o_sh >> 1;
      out_diff <= d_nx;
      if (last) out_err <= d_nx != a_sx;
    end
  // saturating counters bump on the edge entering DONE; clear takes priority
  always_ff @(posedge clk)
    if (rst || cnt_clr) begin
      chk_cnt <= '0;
      err_cnt <= '0;
    end else if (last) begin
      chk_cnt <= chk_cnt + CNT_W'(chk_cnt != '1);
      err_cnt <= err_cnt + CNT_W'(d_nx != a_sx && err_cnt != '1);
    end
endmodule
